// File: rtl/nios_processor_pio_pkg.sv
// Shared definitions for the parametrised Avalon-MM parallel I/O port:
// register map, edge-capture encodings and the bus request bundle.
package nios_processor_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd1;
  localparam logic [2:0] ADDR_EDGECAP = 3'd2;
  localparam logic [2:0] ADDR_OUTSET  = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd4;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } pio_req_t;

  // s is the current synchronised sample, p the sample one cycle older.
  function automatic logic [31:0] edge_detect(input logic [31:0] s,
                                              input logic [31:0] p,
                                              input int          etype);
    case (etype)
      EDGE_RISING:  return s & ~p;
      EDGE_FALLING: return ~s & p;
      default:      return s ^ p;
    endcase
  endfunction

endpackage

// File: rtl/nios_processor_pio_sync.sv
// Input synchroniser, previous-sample register and post-reset priming
// counter; produces the synchronised input and a qualified edge vector.
module nios_processor_pio_sync
  import nios_processor_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] s,
  output logic [DATA_WIDTH-1:0] edge_vec
);

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                  prev_q;
  logic [2:0]                             prime_cnt;
  logic                                   primed;
  logic [31:0]                            edge_full;
  logic                                   unused_edge_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      prime_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
      if (prime_cnt != PRIME_DONE) prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Until the chain and prev register hold real samples, s vs prev would
  // report the reset-to-input step as an edge; suppress until primed.
  assign primed    = (prime_cnt == PRIME_DONE);
  assign edge_full = edge_detect(32'(s), 32'(prev_q), EDGE_TYPE);
  assign edge_vec  = primed ? edge_full[DATA_WIDTH-1:0] : '0;

  assign unused_edge_hi = ^edge_full;

endmodule

// File: rtl/nios_processor_pio_gen.sv
// Avalon-MM PIO slave: output register with atomic set/clear, synchronised
// input, per-bit edge capture, interrupt mask and level irq.
module nios_processor_pio_gen
  import nios_processor_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    EDGE_TYPE    = EDGE_RISING,
  parameter int                    SYNC_STAGES  = 2,
  parameter int                    WRITE1_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  pio_req_t              req;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] ec_clr;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] edge_vec;
  logic                  unused_wdata;

  assign req = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};
  assign wd  = req.wdata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  nios_processor_pio_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .s       (in_sync),
    .edge_vec(edge_vec)
  );

  always_comb begin
    ec_clr = '0;
    if (req.wr && req.addr == ADDR_EDGECAP)
      ec_clr = (WRITE1_CLEAR != 0) ? wd : '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg      <= RESET_VALUE;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (req.wr) begin
        case (req.addr)
          ADDR_DATA:    out_reg  <= wd;
          ADDR_OUTSET:  out_reg  <= out_reg | wd;
          ADDR_OUTCLR:  out_reg  <= out_reg & ~wd;
          ADDR_IRQMASK: irq_mask <= wd;
          default: ;
        endcase
      end
      // Clear first, then OR in new edges so a coincident edge survives.
      edge_capture <= (edge_capture & ~ec_clr) | edge_vec;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[DATA_WIDTH-1:0] = in_sync;
      ADDR_IRQMASK: readdata[DATA_WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[DATA_WIDTH-1:0] = edge_capture;
      ADDR_OUTSET,
      ADDR_OUTCLR:  readdata[DATA_WIDTH-1:0] = out_reg;
      default:      readdata = '0;
    endcase
  end

  assign out_port = out_reg;
  assign irq      = |(edge_capture & irq_mask);

endmodule
